// File: rtl/rom_rd_pkg.sv
// rtl/rom_rd_pkg.sv - shared ROM geometry, length width and FSM encoding for the ROM stream reader
package rom_rd_pkg;

  localparam int ROM_ADDR_W = 11;
  localparam int ROM_DATA_W = 8;
  localparam int ROM_BYTES  = 2048;
  localparam int LEN_W      = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  // A request longer than the ROM is trimmed to one full pass over it.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    return (len > LEN_W'(ROM_BYTES)) ? LEN_W'(ROM_BYTES) : len;
  endfunction

endpackage

// File: rtl/rom_rd_fifo.sv
// rtl/rom_rd_fifo.sv - small synchronous FIFO buffering ROM bytes ahead of the output stream
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   flush               drop all entries (pointers and count return to zero)
//   push, push_data     write one entry
//   pop, pop_data       consume the head entry; pop_data always shows the head
//   full, empty, count  occupancy status
module rom_rd_fifo
  import rom_rd_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = ROM_DATA_W,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // DEPTH need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign pop_data  = r_mem[r_rd_ptr];
  assign w_do_pop  = pop && !empty;
  // A pop frees the head slot in the same cycle, so a full FIFO can still take a push.
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= next_ptr(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/rom_stream_reader.sv
// rtl/rom_stream_reader.sv - fetches a block of consecutive ROM bytes and streams them out with valid/ready
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   start, base_addr, length  command: first address and byte count (clamped to 2048), sampled in IDLE
//   abort                     cancel an active transfer (no done pulse)
//   busy, done                transfer active; one-cycle completion pulse
//   rom_ad, rom_ce, rom_oce   ROM address, read enable (issue cycles only), output-register enable
//   rom_dout                  ROM read data, valid READ_LATENCY cycles after a rom_ce cycle
//   m_data, m_valid, m_ready  output byte stream
module rom_stream_reader
  import rom_rd_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = READ_LATENCY + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ROM_ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]      length,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [ROM_ADDR_W-1:0] rom_ad,
  output logic                  rom_ce,
  output logic                  rom_oce,
  input  logic [ROM_DATA_W-1:0] rom_dout,
  output logic [ROM_DATA_W-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  state_t                  r_state;
  logic [ROM_ADDR_W-1:0]   r_addr;
  logic [LEN_W-1:0]        r_remaining;
  logic                    r_busy;
  logic                    r_done;
  logic [READ_LATENCY-1:0] r_tag;

  logic [CNT_W-1:0]      w_fifo_count;
  logic                  w_empty;
  logic                  w_fifo_full_unused;
  logic [ROM_DATA_W-1:0] w_fifo_data;
  logic [CNT_W-1:0]      w_inflight;
  logic [CNT_W:0]        w_used;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_flush;
  logic                  w_issue;
  logic                  w_drained;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      w_inflight = w_inflight + CNT_W'(r_tag[i]);
    end
  end

  assign w_pop   = !w_empty && m_ready;
  assign w_flush = abort && ((r_state == ISSUE) || (r_state == DRAIN));
  // The tag leaving the last stage marks the cycle whose rom_dout belongs to us.
  assign w_push  = r_tag[READ_LATENCY-1] && !w_flush;

  // Slots already spoken for: buffered bytes plus reads still in the ROM,
  // less the byte leaving this cycle. m_ready reaches rom_ce only through here.
  assign w_used  = (CNT_W+1)'(w_fifo_count) + (CNT_W+1)'(w_inflight) - (CNT_W+1)'(w_pop);
  assign w_issue = (r_state == ISSUE) && (r_remaining != '0) && !abort
                && (w_used < (CNT_W+1)'(FIFO_DEPTH));

  // Counting the byte popped this cycle lets done follow the last transfer directly.
  assign w_drained = (w_inflight == '0)
                  && (w_empty || ((w_fifo_count == CNT_W'(1)) && w_pop));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tag <= '0;
    end else if (w_flush) begin
      r_tag <= '0;
    end else begin
      r_tag[0] <= w_issue;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (length != '0) begin
              r_addr      <= base_addr;
              r_remaining <= clamp_len(length);
              r_busy      <= 1'b1;
              r_state     <= ISSUE;
            end else begin
              r_done  <= 1'b1;
              r_state <= FINISH;
            end
          end
        end
        ISSUE: begin
          if (abort) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (w_issue) begin
            // 11-bit address wraps 0x7FF -> 0x000 on its own.
            r_addr      <= r_addr + ROM_ADDR_W'(1);
            r_remaining <= r_remaining - LEN_W'(1);
            if (r_remaining == LEN_W'(1)) begin
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (abort) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (w_drained) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= FINISH;
          end
        end
        FINISH: begin
          // done was raised on entry; abort here has nothing left to cancel.
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  rom_rd_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(ROM_DATA_W)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (w_flush),
    .push     (w_push),
    .push_data(rom_dout),
    .pop      (w_pop),
    .pop_data (w_fifo_data),
    .full     (w_fifo_full_unused),
    .empty    (w_empty),
    .count    (w_fifo_count)
  );

  assign busy    = r_busy;
  assign done    = r_done;
  assign rom_ad  = r_addr;
  assign rom_ce  = w_issue;
  assign rom_oce = r_busy;
  assign m_valid = !w_empty;
  assign m_data  = w_fifo_data;

endmodule

// File: tb/tb_rom_stream_reader.sv
// tb/tb_rom_stream_reader.sv - self-checking bench for rom_stream_reader at read latencies 1 and 2
module tb_rom_stream_reader;

  logic        clk = 1'b0;
  logic        reset_n, start, abort, m_ready;
  logic [10:0] base_addr;
  logic [11:0] length;
  logic        sel;

  always #5 clk = ~clk;

  // Instance A: READ_LATENCY=1
  logic        a_busy, a_done, a_ce, a_oce, a_valid;
  logic [10:0] a_ad;
  logic [7:0]  a_dout, a_data;
  rom_stream_reader #(.READ_LATENCY(1)) u_dut_l1 (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr), .length(length),
    .abort(abort), .busy(a_busy), .done(a_done), .rom_ad(a_ad), .rom_ce(a_ce),
    .rom_oce(a_oce), .rom_dout(a_dout), .m_data(a_data), .m_valid(a_valid), .m_ready(m_ready)
  );
  always @(posedge clk) if (a_ce) a_dout <= a_ad[7:0] ^ 8'hA5;

  // Instance B: READ_LATENCY=2
  logic        b_busy, b_done, b_ce, b_oce, b_valid;
  logic [10:0] b_ad;
  logic [7:0]  b_q, b_dout, b_data;
  rom_stream_reader #(.READ_LATENCY(2)) u_dut_l2 (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr), .length(length),
    .abort(abort), .busy(b_busy), .done(b_done), .rom_ad(b_ad), .rom_ce(b_ce),
    .rom_oce(b_oce), .rom_dout(b_dout), .m_data(b_data), .m_valid(b_valid), .m_ready(m_ready)
  );
  always @(posedge clk) begin
    if (b_ce)  b_q    <= b_ad[7:0] ^ 8'hA5;
    if (b_oce) b_dout <= b_q;
  end

  logic        o_busy, o_done, o_ce, o_oce, o_valid;
  logic [10:0] o_ad;
  logic [7:0]  o_data;
  always_comb begin
    if (sel) begin
      o_busy = b_busy; o_done = b_done; o_ce = b_ce; o_oce = b_oce;
      o_valid = b_valid; o_ad = b_ad; o_data = b_data;
    end else begin
      o_busy = a_busy; o_done = a_done; o_ce = a_ce; o_oce = a_oce;
      o_valid = a_valid; o_ad = a_ad; o_data = a_data;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cur_lat, cur_depth;

  logic [10:0] ad_log[$];
  logic [7:0]  data_log[$];
  int          xfer_cyc[$];
  int          cyc, n_done, done_cyc, hold_err, max_out;
  logic        busy_at_done, busy1, prev_stall;
  logic [7:0]  prev_data;

  task automatic clear_logs();
    ad_log.delete(); data_log.delete(); xfer_cyc.delete();
    cyc = 0; n_done = 0; done_cyc = -1; hold_err = 0; max_out = 0;
    busy_at_done = 1'bx; busy1 = 1'bx; prev_stall = 1'b0; prev_data = '0;
  endtask

  // One clock: drive inputs after the falling edge, observe just before the rising edge.
  task automatic step(input logic rdy, input logic st, input logic ab);
    int outstanding;
    @(negedge clk);
    m_ready = rdy; start = st; abort = ab;
    #1;
    if (prev_stall && (o_valid !== 1'b1 || o_data !== prev_data)) hold_err++;
    if (o_ce === 1'b1) ad_log.push_back(o_ad);
    if (o_valid === 1'b1 && rdy) begin
      data_log.push_back(o_data);
      xfer_cyc.push_back(cyc);
    end
    if (o_done === 1'b1) begin
      n_done++; done_cyc = cyc; busy_at_done = o_busy;
    end
    if (cyc == 1) busy1 = o_busy;
    outstanding = ad_log.size() - data_log.size();
    if (outstanding > max_out) max_out = outstanding;
    prev_stall = (o_valid === 1'b1) && !rdy && !ab;
    prev_data  = o_data;
    cyc++;
  endtask

  // mode 0: always ready; 1: toggle for 20 cycles, low 10, then high; 2: random
  function automatic logic ready_for(input int mode, input int c);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (c < 20) ? c[0] : (c >= 30);
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic run(input logic [10:0] b, input logic [11:0] l, input int mode,
                     input int budget, input int inj_at);
    logic st;
    clear_logs();
    base_addr = b; length = l;
    step(1'b1, 1'b1, 1'b0);
    while (n_done == 0 && cyc < budget) begin
      st = (cyc == inj_at);
      if (st) base_addr = 11'h100;
      step(ready_for(mode, cyc), st, 1'b0);
    end
    repeat (3) step(1'b1, 1'b0, 1'b0);
  endtask

  // Reference: byte i of a block is ((base + i) mod 2048)[7:0] ^ 0xA5.
  function automatic int stream_errs(input logic [10:0] b, input int n);
    int e;
    logic [10:0] a;
    logic [7:0] exp_b;
    e = 0;
    if (data_log.size() != n) e++;
    for (int i = 0; i < data_log.size() && i < n; i++) begin
      a = b + 11'(i);
      exp_b = a[7:0] ^ 8'hA5;
      if (data_log[i] !== exp_b) e++;
    end
    return e;
  endfunction

  task automatic test_reset();
    @(negedge clk); reset_n = 1'b0; start = 0; abort = 0; m_ready = 0; #1;
    n_checks++;
    if ({o_busy, o_done, o_ce, o_oce, o_valid} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl lat=%0d: got %b expected 00000", cur_lat,
                         {o_busy, o_done, o_ce, o_oce, o_valid});
    end
    n_checks++;
    if (o_ad !== 11'h000 || o_data !== 8'h00) begin
      n_fail++; $display("FAIL reset_data lat=%0d: ad=%h data=%h expected 000/00", cur_lat, o_ad, o_data);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    clear_logs();
    repeat (3) step(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (ad_log.size() != 0 || n_done != 0 || o_busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle lat=%0d: ce=%0d done=%0d busy=%b expected 0/0/0",
                         cur_lat, ad_log.size(), n_done, o_busy);
    end
  endtask

  task automatic test_basic();
    int span;
    run(11'h000, 12'd6, 0, 60, -1);
    n_checks++;
    if (stream_errs(11'h000, 6) != 0) begin
      n_fail++; $display("FAIL basic_stream lat=%0d: %0d byte errors expected 0", cur_lat, stream_errs(11'h000, 6));
    end
    span = (xfer_cyc.size() == 6) ? xfer_cyc[5] - xfer_cyc[0] : -1;
    n_checks++;
    if (span != 5) begin
      n_fail++; $display("FAIL basic_rate lat=%0d: 6 bytes spanned %0d cycles expected 5", cur_lat, span);
    end
    n_checks++;
    if (n_done != 1 || xfer_cyc.size() == 0 || done_cyc != xfer_cyc[xfer_cyc.size()-1] + 1) begin
      n_fail++; $display("FAIL basic_done lat=%0d: done count %0d at cycle %0d expected 1 right after last byte",
                         cur_lat, n_done, done_cyc);
    end
    n_checks++;
    if (busy_at_done !== 1'b0 || busy1 !== 1'b1) begin
      n_fail++; $display("FAIL basic_busy lat=%0d: busy at done=%b after start=%b expected 0/1",
                         cur_lat, busy_at_done, busy1);
    end
  endtask

  task automatic test_wrap();
    int ad_err;
    run(11'h7FE, 12'd4, 0, 60, -1);
    ad_err = (ad_log.size() == 4) ? 0 : 1;
    for (int i = 0; i < ad_log.size() && i < 4; i++)
      if (ad_log[i] !== 11'(11'h7FE + 11'(i))) ad_err++;
    n_checks++;
    if (ad_err != 0) begin
      n_fail++; $display("FAIL wrap_addr lat=%0d: %0d address errors (%0d reads) expected 0", cur_lat, ad_err, ad_log.size());
    end
    n_checks++;
    if (stream_errs(11'h7FE, 4) != 0 || n_done != 1) begin
      n_fail++; $display("FAIL wrap_stream lat=%0d: %0d byte errors, done %0d expected 0/1",
                         cur_lat, stream_errs(11'h7FE, 4), n_done);
    end
  endtask

  task automatic test_backpressure();
    run(11'h123, 12'd16, 1, 200, -1);
    n_checks++;
    if (stream_errs(11'h123, 16) != 0 || ad_log.size() != 16) begin
      n_fail++; $display("FAIL bp_stream lat=%0d: %0d byte errors, %0d reads expected 0/16",
                         cur_lat, stream_errs(11'h123, 16), ad_log.size());
    end
    n_checks++;
    if (hold_err != 0) begin
      n_fail++; $display("FAIL bp_hold lat=%0d: %0d unstable stalled cycles expected 0", cur_lat, hold_err);
    end
    n_checks++;
    if (max_out != cur_depth) begin
      n_fail++; $display("FAIL bp_credit lat=%0d: peak outstanding %0d expected %0d", cur_lat, max_out, cur_depth);
    end
    n_checks++;
    if (n_done != 1) begin
      n_fail++; $display("FAIL bp_done lat=%0d: done count %0d expected 1", cur_lat, n_done);
    end
  endtask

  task automatic test_zero_clamp();
    run(11'h055, 12'd0, 0, 20, -1);
    n_checks++;
    if (ad_log.size() != 0 || n_done != 1 || done_cyc < 1 || done_cyc > 2) begin
      n_fail++; $display("FAIL zero_len lat=%0d: reads %0d done %0d at cycle %0d expected 0/1 at 1..2",
                         cur_lat, ad_log.size(), n_done, done_cyc);
    end
    run(11'h000, 12'd4095, 2, 9000, -1);
    n_checks++;
    if (stream_errs(11'h000, 2048) != 0 || ad_log.size() != 2048) begin
      n_fail++; $display("FAIL clamp_stream lat=%0d: %0d byte errors, %0d bytes, %0d reads expected 0/2048/2048",
                         cur_lat, stream_errs(11'h000, 2048), data_log.size(), ad_log.size());
    end
    n_checks++;
    if (n_done != 1 || hold_err != 0 || max_out > cur_depth) begin
      n_fail++; $display("FAIL clamp_done lat=%0d: done %0d hold %0d peak %0d expected 1/0/<=%0d",
                         cur_lat, n_done, hold_err, max_out, cur_depth);
    end
  endtask

  task automatic test_abort_reset();
    int n_ce;
    clear_logs();
    base_addr = 11'h000; length = 12'd10;
    step(1'b1, 1'b1, 1'b0);
    while (data_log.size() < 3 && cyc < 30) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    n_ce = ad_log.size();
    step(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0 || data_log.size() != 3) begin
      n_fail++; $display("FAIL abort_flush lat=%0d: valid=%b busy=%b bytes=%0d expected 0/0/3",
                         cur_lat, o_valid, o_busy, data_log.size());
    end
    repeat (5) step(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (ad_log.size() != n_ce || n_done != 0 || data_log.size() != 3) begin
      n_fail++; $display("FAIL abort_quiet lat=%0d: reads %0d->%0d done %0d bytes %0d expected no change/0/3",
                         cur_lat, n_ce, ad_log.size(), n_done, data_log.size());
    end
    run(11'h010, 12'd2, 0, 40, -1);
    n_checks++;
    if (stream_errs(11'h010, 2) != 0 || n_done != 1) begin
      n_fail++; $display("FAIL abort_restart lat=%0d: %0d byte errors done %0d expected 0/1",
                         cur_lat, stream_errs(11'h010, 2), n_done);
    end
    clear_logs();
    base_addr = 11'h200; length = 12'd20;
    step(1'b0, 1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b0, 1'b0);
    @(negedge clk); reset_n = 1'b0; #1;
    n_checks++;
    if ({o_busy, o_done, o_ce, o_oce, o_valid} !== 5'b0 || o_ad !== 11'h0 || o_data !== 8'h0) begin
      n_fail++; $display("FAIL midreset lat=%0d: ctrl=%b ad=%h data=%h expected all zero", cur_lat,
                         {o_busy, o_done, o_ce, o_oce, o_valid}, o_ad, o_data);
    end
    @(negedge clk); reset_n = 1'b1;
    clear_logs();
    repeat (6) step(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (n_done != 0 || ad_log.size() != 0 || data_log.size() != 0) begin
      n_fail++; $display("FAIL midreset_quiet lat=%0d: done %0d reads %0d bytes %0d expected 0/0/0",
                         cur_lat, n_done, ad_log.size(), data_log.size());
    end
  endtask

  task automatic test_start_busy();
    run(11'h000, 12'd8, 0, 60, 3);
    n_checks++;
    if (stream_errs(11'h000, 8) != 0 || ad_log.size() != 8 || n_done != 1) begin
      n_fail++; $display("FAIL start_busy lat=%0d: %0d byte errors, %0d reads, done %0d expected 0/8/1",
                         cur_lat, stream_errs(11'h000, 8), ad_log.size(), n_done);
    end
  endtask

  task automatic test_random();
    logic [10:0] b;
    int l, ad_err;
    for (int k = 0; k < 6; k++) begin
      b = 11'($urandom_range(0, 2047));
      l = $urandom_range(1, 40);
      run(b, 12'(l), 2, 400, -1);
      ad_err = (ad_log.size() == l) ? 0 : 1;
      for (int i = 0; i < ad_log.size() && i < l; i++)
        if (ad_log[i] !== 11'(b + 11'(i))) ad_err++;
      n_checks++;
      if (stream_errs(b, l) != 0 || ad_err != 0 || n_done != 1 || hold_err != 0 || max_out > cur_depth) begin
        n_fail++; $display("FAIL random lat=%0d base=%h len=%0d: byte err %0d addr err %0d done %0d hold %0d peak %0d expected 0/0/1/0/<=%0d",
                           cur_lat, b, l, stream_errs(b, l), ad_err, n_done, hold_err, max_out, cur_depth);
      end
    end
  endtask

  initial begin
    reset_n = 1'b1; start = 1'b0; abort = 1'b0; m_ready = 1'b0;
    base_addr = '0; length = '0; sel = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      cur_lat = s + 1;
      cur_depth = cur_lat + 1;
      test_reset();
      test_basic();
      test_wrap();
      test_backpressure();
      test_zero_clamp();
      test_abort_reset();
      test_start_busy();
      test_random();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
